// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: datapath width, opcode codes
// and the issue-controller power state encoding.
package alu_pkg;

   localparam int ALU_W = 16;
   localparam int OP_W  = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR = 3'b110;
   localparam logic [OP_W-1:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      SLEEP = 2'd0,
      WAKE  = 2'd1,
      RUN   = 2'd2,
      COOL  = 2'd3
   } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; no pass-through, so an
// entry written in one cycle is visible at the head from the next.
module alu_cmd_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 39,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: buffers commands, issues one per cycle, isolates operands
// while idle, requests ALU sleep after an idle window and aligns result tags.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TAG_W       = 4,
   parameter int IDLE_CYCLES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ALU_W-1:0]           cmd_a,
   input  logic [ALU_W-1:0]           cmd_b,
   input  logic [OP_W-1:0]            cmd_op,
   input  logic [TAG_W-1:0]           cmd_tag,
   input  logic                       issue_hold,
   output logic [ALU_W-1:0]           alu_a,
   output logic [ALU_W-1:0]           alu_b,
   output logic [OP_W-1:0]            alu_op,
   output logic                       alu_enable,
   output logic                       alu_sleep,
   output logic                       rsp_valid,
   output logic [TAG_W-1:0]           rsp_tag,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int IDLE_W = $clog2(IDLE_CYCLES);
   localparam int DATA_W = 2 * ALU_W + OP_W + TAG_W;

   issue_state_e      state_q, state_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              sleep_q, sleep_d;
   logic [ALU_W-1:0]  a_q, b_q;
   logic [OP_W-1:0]   op_q;
   logic [TAG_W-1:0]  tag1_q, rsp_tag_q;
   logic              en_q, rsp_valid_q;

   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  count;
   logic              full, empty, push, issue;

   assign push  = cmd_valid && !full;
   assign issue = ((state_q == RUN) || (state_q == COOL)) && !empty && !issue_hold;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (issue),
      .wdata_i({cmd_tag, cmd_op, cmd_b, cmd_a}),
      .rdata_o(head),
      .count_o(count),
      .full_o (full),
      .empty_o(empty)
   );

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      case (state_q)
         SLEEP: if (!empty) state_d = WAKE;
         WAKE:  state_d = RUN;
         RUN: begin
            if (empty || (count == CNT_W'(1) && issue && !push)) begin
               state_d = COOL;
               idle_d  = '0;
            end
         end
         COOL: begin
            // Pending work (even when held) keeps the ALU awake.
            if (issue || !empty)                          state_d = RUN;
            else if (idle_q == IDLE_W'(IDLE_CYCLES - 1))  state_d = SLEEP;
            else                                          idle_d  = idle_q + IDLE_W'(1);
         end
         default: state_d = SLEEP;
      endcase
      // Sleep drops on the WAKE entry edge but rises one cycle after SLEEP entry.
      sleep_d = (state_q == SLEEP) && (state_d == SLEEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SLEEP;
         idle_q      <= '0;
         sleep_q     <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         tag1_q      <= '0;
         en_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         idle_q      <= idle_d;
         sleep_q     <= sleep_d;
         en_q        <= issue;
         rsp_valid_q <= en_q;
         if (en_q) rsp_tag_q <= tag1_q;
         if (issue) begin
            a_q    <= head[ALU_W-1:0];
            b_q    <= head[2*ALU_W-1:ALU_W];
            op_q   <= head[2*ALU_W+OP_W-1:2*ALU_W];
            tag1_q <= head[DATA_W-1:2*ALU_W+OP_W];
         end
      end
   end

   assign cmd_ready  = !full;
   assign fifo_count = count;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign alu_enable = en_q;
   assign alu_sleep  = sleep_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed timing scenarios followed by
// randomized traffic compared against a queue-based behavioural model.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int DEPTH       = 4;
   localparam int TAG_W       = 4;
   localparam int IDLE_CYCLES = 8;
   localparam int CNT_W       = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [15:0]      cmd_a = '0, cmd_b = '0;
   logic [2:0]       cmd_op = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic             issue_hold = 1'b0;
   logic [15:0]      alu_a, alu_b;
   logic [2:0]       alu_op;
   logic             alu_enable, alu_sleep, rsp_valid;
   logic [TAG_W-1:0] rsp_tag;
   logic [CNT_W-1:0] fifo_count;

   int total = 0;
   int bad   = 0;

   alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDLE_CYCLES(IDLE_CYCLES)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .issue_hold(issue_hold), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_enable(alu_enable), .alu_sleep(alu_sleep), .rsp_valid(rsp_valid),
      .rsp_tag(rsp_tag), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input bit v, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag);
      cmd_valid = v;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_tag   = tag;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      issue_hold = 1'b0;
      set_cmd(0, '0, '0, '0, '0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct packed {
      logic [15:0]      a;
      logic [15:0]      b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             mq[$];
   bit               m_asleep, m_settle, m_cool;
   int               m_idle;
   logic [15:0]      m_a, m_b;
   logic [2:0]       m_op;
   logic [TAG_W-1:0] m_tag1, m_rt;
   bit               m_en, m_rv, m_sleep;

   task automatic model_reset();
      mq.delete();
      m_asleep = 1; m_settle = 0; m_cool = 0; m_idle = 0;
      m_a = '0; m_b = '0; m_op = '0; m_tag1 = '0; m_rt = '0;
      m_en = 0; m_rv = 0; m_sleep = 1;
   endtask

   // Advances the model across one clock edge using the currently driven inputs.
   task automatic model_step();
      int   sz = mq.size();
      bit   push = cmd_valid && (sz < DEPTH);
      bit   iss  = !m_asleep && !m_settle && (sz > 0) && !issue_hold;
      bit   was_asleep = m_asleep;
      cmd_t hd;
      m_rv = m_en;
      if (m_en) m_rt = m_tag1;
      m_en = iss;
      if (iss) begin
         hd = mq[0];
         m_a = hd.a; m_b = hd.b; m_op = hd.op; m_tag1 = hd.tag;
      end
      if (m_asleep) begin
         if (sz > 0) begin m_asleep = 0; m_settle = 1; end
      end else if (m_settle) begin
         m_settle = 0;
      end else if (!m_cool) begin
         if (sz == 0 || (iss && !push && sz == 1)) begin m_cool = 1; m_idle = 0; end
      end else begin
         if (iss || sz > 0)                m_cool = 0;
         else if (m_idle == IDLE_CYCLES-1) begin m_cool = 0; m_asleep = 1; end
         else                              m_idle++;
      end
      m_sleep = was_asleep && m_asleep;
      if (iss)  void'(mq.pop_front());
      if (push) mq.push_back('{cmd_a, cmd_b, cmd_op, cmd_tag});
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_cmd(0, '0, '0, '0, '0);
      tick();
      total++;
      if ({alu_a, alu_b, alu_op} !== 35'd0) begin
         bad++; $display("FAIL reset_operands got=%h/%h/%h exp=0", alu_a, alu_b, alu_op);
      end
      total++;
      if ({alu_enable, rsp_valid, rsp_tag} !== '0) begin
         bad++; $display("FAIL reset_pipe got en=%b rv=%b tag=%h exp 0", alu_enable, rsp_valid, rsp_tag);
      end
      total++;
      if ({alu_sleep, cmd_ready, fifo_count} !== {1'b1, 1'b1, CNT_W'(0)}) begin
         bad++; $display("FAIL reset_status got sleep=%b ready=%b count=%0d exp 1/1/0",
                         alu_sleep, cmd_ready, fifo_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_wake();
      do_reset();
      set_cmd(1, 16'h0003, 16'h0004, OP_ADD, 4'd5);
      tick();
      set_cmd(0, '0, '0, '0, '0);
      for (int c = 1; c <= 5; c++) begin
         total++;
         if (alu_sleep !== (c < 2)) begin
            bad++; $display("FAIL wake_sleep cycle=%0d got=%b exp=%b", c, alu_sleep, (c < 2));
         end
         total++;
         if (alu_enable !== (c == 4)) begin
            bad++; $display("FAIL wake_enable cycle=%0d got=%b exp=%b", c, alu_enable, (c == 4));
         end
         total++;
         if (rsp_valid !== (c == 5)) begin
            bad++; $display("FAIL wake_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, (c == 5));
         end
         if (c == 4) begin
            total++;
            if ({alu_a, alu_b, alu_op} !== {16'h0003, 16'h0004, OP_ADD}) begin
               bad++; $display("FAIL wake_operands got=%h/%h/%h exp=0003/0004/0", alu_a, alu_b, alu_op);
            end
         end
         if (c == 5) begin
            total++;
            if (rsp_tag !== 4'd5) begin
               bad++; $display("FAIL wake_rsp_tag got=%0d exp=5", rsp_tag);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int               en_cyc[$];
      int               rsp_cyc[$];
      logic [TAG_W-1:0] tags[$];
      int               max_cnt = 0;
      do_reset();
      set_cmd(1, 16'h0001, 16'h0001, OP_SUB, 4'd0);
      tick();
      set_cmd(0, '0, '0, '0, '0);
      repeat (4) tick();
      for (int i = 0; i < 12; i++) begin
         if (i < 4) set_cmd(1, 16'h0A00 + 16'(i), 16'h0B00, OP_MUL, TAG_W'(i + 1));
         else       set_cmd(0, '0, '0, '0, '0);
         tick();
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (alu_enable) begin
            total++;
            if (alu_a !== 16'h0A00 + 16'(en_cyc.size())) begin
               bad++; $display("FAIL b2b_operand got=%h exp=%h", alu_a, 16'h0A00 + 16'(en_cyc.size()));
            end
            en_cyc.push_back(i);
         end
         if (rsp_valid) begin
            rsp_cyc.push_back(i);
            tags.push_back(rsp_tag);
         end
      end
      total++;
      if (en_cyc.size() != 4 || (en_cyc[en_cyc.size()-1] - en_cyc[0]) != 3) begin
         bad++; $display("FAIL b2b_enable_run got=%0d enables exp=4 consecutive", en_cyc.size());
      end
      total++;
      if (tags.size() != 4 || (rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[0]) != 3) begin
         bad++; $display("FAIL b2b_rsp_run got=%0d responses exp=4 consecutive", tags.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (tags[k] !== TAG_W'(k + 1)) begin
               bad++; $display("FAIL b2b_rsp_tag idx=%0d got=%0d exp=%0d", k, tags[k], k + 1);
            end
         end
      end
      total++;
      if (max_cnt > 1) begin
         bad++; $display("FAIL b2b_fifo_count got=%0d exp<=1", max_cnt);
      end
   endtask

   task automatic test_full();
      int n_en = 0;
      do_reset();
      issue_hold = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         if (c <= 4) set_cmd(1, 16'h0C00 + 16'(c), 16'h0D00, OP_OR, TAG_W'(c + 1));
         else        set_cmd(0, '0, '0, '0, '0);
         if (c == 4) begin
            total++;
            if (cmd_ready !== 1'b0 || fifo_count !== CNT_W'(4)) begin
               bad++; $display("FAIL full_ready got ready=%b count=%0d exp 0/4", cmd_ready, fifo_count);
            end
         end
         tick();
      end
      // now in cycle 6, FIFO must still hold exactly the first four
      total++;
      if (fifo_count !== CNT_W'(4) || cmd_ready !== 1'b0) begin
         bad++; $display("FAIL full_hold got count=%0d ready=%b exp 4/0", fifo_count, cmd_ready);
      end
      issue_hold = 1'b0;
      tick();
      total++;
      if (cmd_ready !== 1'b1 || fifo_count !== CNT_W'(3)) begin
         bad++; $display("FAIL full_release got ready=%b count=%0d exp 1/3", cmd_ready, fifo_count);
      end
      for (int c = 7; c <= 12; c++) begin
         if (alu_enable) begin
            total++;
            if (alu_a !== 16'h0C00 + 16'(n_en)) begin
               bad++; $display("FAIL full_order got=%h exp=%h", alu_a, 16'h0C00 + 16'(n_en));
            end
            n_en++;
         end
         if (rsp_valid && rsp_tag === 4'd5) begin
            total++; bad++;
            $display("FAIL full_rejected got tag=5 exp none");
         end
         tick();
      end
      total++;
      if (n_en != 4 || fifo_count !== CNT_W'(0)) begin
         bad++; $display("FAIL full_drain got issues=%0d count=%0d exp 4/0", n_en, fifo_count);
      end
   endtask

   task automatic test_sleep();
      do_reset();
      set_cmd(1, 16'hBEEF, 16'h1234, OP_XOR, 4'd3);
      tick();
      set_cmd(0, '0, '0, '0, '0);
      // last issue happens in cycle 3
      for (int c = 1; c <= 14; c++) begin
         total++;
         if (alu_sleep !== (c < 2 || c >= 13)) begin
            bad++; $display("FAIL sleep_timing cycle=%0d got=%b exp=%b", c, alu_sleep, (c < 2 || c >= 13));
         end
         if (c >= 4) begin
            total++;
            if ({alu_a, alu_b, alu_op} !== {16'hBEEF, 16'h1234, OP_XOR}) begin
               bad++; $display("FAIL sleep_isolation cycle=%0d got=%h/%h/%h exp=beef/1234/4",
                               c, alu_a, alu_b, alu_op);
            end
         end
         tick();
      end
   endtask

   task automatic test_idle_interrupt();
      do_reset();
      set_cmd(1, 16'h0011, 16'h0001, OP_SHL, 4'd7);
      tick();
      for (int c = 1; c <= 21; c++) begin
         if (c == 9) set_cmd(1, 16'h0022, 16'h0002, OP_SHR, 4'd8);
         else        set_cmd(0, '0, '0, '0, '0);
         total++;
         if (alu_sleep !== (c < 2 || c >= 21)) begin
            bad++; $display("FAIL idle_sleep cycle=%0d got=%b exp=%b", c, alu_sleep, (c < 2 || c >= 21));
         end
         total++;
         if (alu_enable !== (c == 4 || c == 11)) begin
            bad++; $display("FAIL idle_enable cycle=%0d got=%b exp=%b", c, alu_enable, (c == 4 || c == 11));
         end
         if (c == 11) begin
            total++;
            if (alu_a !== 16'h0022) begin
               bad++; $display("FAIL idle_operand got=%h exp=0022", alu_a);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_cmd(1, 16'h0100 + 16'(c), 16'h0200, OP_AND, TAG_W'(c + 1));
         tick();
      end
      set_cmd(0, '0, '0, '0, '0);
      total++;
      if (fifo_count !== CNT_W'(3) || alu_enable !== 1'b1) begin
         bad++; $display("FAIL midrst_setup got count=%0d en=%b exp 3/1", fifo_count, alu_enable);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({fifo_count, rsp_valid, alu_sleep, alu_enable, cmd_ready} !== {CNT_W'(0), 1'b0, 1'b1, 1'b0, 1'b1}) begin
         bad++; $display("FAIL midrst_immediate got count=%0d rv=%b sleep=%b en=%b ready=%b exp 0/0/1/0/1",
                         fifo_count, rsp_valid, alu_sleep, alu_enable, cmd_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (rsp_valid !== 1'b0 || alu_enable !== 1'b0 || fifo_count !== CNT_W'(0)) begin
            bad++; $display("FAIL midrst_stale cycle=%0d got rv=%b en=%b count=%0d exp 0/0/0",
                            c, rsp_valid, alu_enable, fifo_count);
         end
      end
   endtask

   task automatic test_random();
      logic [45:0] got, exp;
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         bit quiet = (c % 150) > 110;
         set_cmd(!quiet && ($urandom_range(99) < 55), 16'($urandom), 16'($urandom),
                 3'($urandom_range(7)), TAG_W'($urandom_range(15)));
         issue_hold = ($urandom_range(99) < 25);
         model_step();
         tick();
         exp = {m_a, m_b, m_op, m_en, m_sleep, m_rv, m_rt, CNT_W'(mq.size()), (mq.size() < DEPTH)};
         got = {alu_a, alu_b, alu_op, alu_enable, alu_sleep, rsp_valid, rsp_tag, fifo_count, cmd_ready};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL random cycle=%0d got=%h exp=%h", c, got, exp);
         end
      end
      set_cmd(0, '0, '0, '0, '0);
      issue_hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wake();
      test_back_to_back();
      test_full();
      test_sleep();
      test_idle_interrupt();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command issue stage directly upstream of the 16-bit ALU (ADD/SUB/AND/OR/XOR/SHL/SHR/MUL, 1-cycle registered result).
- Buffers operand/opcode commands in a small FIFO and issues at most one per cycle.
- Holds ALU operand lines stable when idle (operand isolation) and drives the ALU enable plus a sleep request for clock gating after a programmable idle window.
- Returns a tag-aligned response strobe so downstream logic knows which ALU result is valid.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the command tag carried alongside each op.
- IDLE_CYCLES, 8, consecutive non-issue cycles in COOL before sleep is requested; >= 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_op  in  3  ALU opcode; all 8 codes legal.
- cmd_tag  in  TAG_W  command identifier.
- issue_hold  in  1  downstream back-pressure; no issue while high.
- alu_a  out  16  registered operand A to ALU.
- alu_b  out  16  registered operand B to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_enable  out  1  high exactly in cycles where alu_a/alu_b/alu_op carry a newly issued command.
- alu_sleep  out  1  clock-gate request for the ALU.
- rsp_valid  out  1  ALU result for rsp_tag is valid this cycle.
- rsp_tag  out  TAG_W  tag of the result currently on the ALU output.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset values:
  - alu_a/alu_b/alu_op = 0; alu_enable = 0; rsp_valid = 0; rsp_tag = 0.
  - alu_sleep = 1; fifo_count = 0; cmd_ready = 1.
  - State = SLEEP.
  - Reset asserted mid-operation flushes the FIFO and all in-flight tags; no rsp_valid is generated for them.
- Push: cmd_valid & cmd_ready.
  - No pass-through: an entry pushed in cycle N is poppable from N+1.
  - When full, cmd_ready is low, so a same-cycle pop does not admit a push.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
- Issue (pop): state is RUN or COOL, FIFO non-empty, and issue_hold low.
  - On issue, alu_a/alu_b/alu_op/tag register the FIFO head at the clock edge.
  - alu_enable is high in cycle N+1; rsp_valid/rsp_tag are high in N+2 (tag pipeline depth 2).
  - Without an issue, alu_a/alu_b/alu_op hold their previous values and alu_enable is 0.
- FSM:
  - SLEEP: alu_sleep = 1. If FIFO non-empty, go to WAKE and deassert alu_sleep on entry.
  - WAKE: exactly 1 cycle with no issue (gate settle), then go to RUN.
  - RUN: issue when allowed. If the FIFO is empty, or becomes empty after this cycle's pop with no push, go to COOL and clear idle_cnt.
  - COOL: issue is allowed. On an issue, or if FIFO non-empty, go to RUN.
    - Otherwise idle_cnt increments.
    - At idle_cnt == IDLE_CYCLES-1, go to SLEEP; alu_sleep = 1 from the next cycle.
    - issue_hold with a non-empty FIFO counts as RUN, not idle: no sleep while work is pending.
- Since IDLE_CYCLES >= 2, the last rsp_valid always precedes alu_sleep assertion.
- Latency summary:
  - Awake: push N, issue N+1, enable N+2, rsp N+3.
  - From SLEEP: push N, WAKE N+2, issue N+3, enable N+4, rsp N+5.
- Throughput is 1 command/cycle sustained in RUN with issue_hold low.
- fifo_count and cmd_ready are registered; pointers wrap modulo DEPTH.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_ADD..OP_MUL (3'b000..3'b111).
  - ALU_W = 16.
  - FSM state encoding SLEEP/WAKE/RUN/COOL.
- One natural sub-module: alu_cmd_fifo (synchronous FIFO, DEPTH x (16+16+3+TAG_W), count/full/empty outputs).
- FSM, idle counter and tag pipeline live in the top.

Test Plan:
- Wake from reset: release rst, push {a=0x0003, b=0x0004, op=ADD, tag=5} at cycle 0.
  - alu_sleep falls cycle 2.
  - alu_enable with alu_a=0x0003, alu_b=0x0004, alu_op=000 at cycle 4.
  - rsp_valid with tag 5 at cycle 5.
- Back-to-back: while awake, push 4 ops (tags 1-4) on consecutive cycles.
  - alu_enable is high for 4 consecutive cycles.
  - rsp tags 1, 2, 3, 4 appear on consecutive cycles; fifo_count never exceeds 1.
- Full/back-pressure: hold issue_hold=1 and push 5 ops.
  - cmd_ready drops after the 4th push; fifo_count=4; 5th is not accepted.
  - Release issue_hold: 4 issues in order, cmd_ready returns the cycle after the first pop.
- Sleep timing: IDLE_CYCLES=8, last issue in cycle N, no further pushes.
  - alu_sleep = 1 from cycle N+10; alu_a/b/op hold last values throughout.
- Idle interrupted: a push arrives in COOL when idle_cnt=5.
  - Issued the next cycle without a WAKE cycle; alu_sleep stays 0; idle_cnt restarts at next COOL entry.
- Reset mid-operation: assert rst with 3 entries queued and 1 in flight.
  - Immediately: fifo_count=0, rsp_valid=0, alu_sleep=1, alu_enable=0.
  - No stale rsp_valid after rst deasserts.
